// File: rtl/ex_stall_ctrl.sv
// ex_stall_ctrl: stall/flush controller for the six-stage pipeline.
// It sequences multi-cycle EX ops, merges ID load-use stalls into one
// per-stage stall vector, and turns MEM flush requests into a one-cycle flush.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   stallreq_id   load-use hazard from ID (level)
//   mc_start      EX holds a multi-cycle op; sampled only in IDLE
//   mc_len        extra EX cycles N for that op
//   flush_req     exception/redirect request from MEM (level)
//   stall[5:0]    per-stage hold: pc, if_id, id_ex/ID, EX, MEM, WB
//   flush         pipeline registers load NOPs this cycle
//   mc_busy       multi-cycle sequence running
//   mc_cnt        remaining count register (0 outside RUN)
//   mc_done       one-cycle pulse; EX result is final
//
// Optional feature macro: EX_STALL_CTRL_FLUSH_EN enables the FLUSH state and
// flush_req handling. Without it, flush_req is ignored and flush is 0.

module ex_stall_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_len,
  input  logic                flush_req,
  output logic [5:0]          stall,
  output logic                flush,
  output logic                mc_busy,
  output logic [MC_CNT_W-1:0] mc_cnt,
  output logic                mc_done
);

`ifdef EX_STALL_CTRL_FLUSH_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FLUSH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  localparam logic [5:0] STALL_MC = 6'b001111;  // hold pc..EX while EX iterates
  localparam logic [5:0] STALL_LU = 6'b000111;  // hold pc..ID for a load-use bubble

  state_t              state, state_nxt;
  logic [MC_CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]          stall_c;
  logic                flush_hit;

`ifdef EX_STALL_CTRL_FLUSH_EN
  assign flush_hit = flush_req;
`else
  logic unused_flush_req;
  assign unused_flush_req = flush_req;
  assign flush_hit        = 1'b0;
`endif

  // Next-state and Mealy stall decode. flush_req outranks the sequence,
  // which outranks the ID load-use request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 6'b000000;
    case (state)
      IDLE: begin
        if (flush_hit) begin
`ifdef EX_STALL_CTRL_FLUSH_EN
          state_nxt = FLUSH;
`endif
          if (stallreq_id) stall_c = STALL_LU;
        end else if (mc_start && (mc_len != '0)) begin
          stall_c   = STALL_MC;
          cnt_nxt   = mc_len - 1'b1;
          // N==1 needs only this one stalled cycle, so skip RUN entirely
          state_nxt = (mc_len == MC_CNT_W'(1)) ? DONE : RUN;
        end else if (stallreq_id) begin
          stall_c = STALL_LU;
        end
      end
      RUN: begin
        stall_c = STALL_MC;
        if (flush_hit) begin
          cnt_nxt = '0;
`ifdef EX_STALL_CTRL_FLUSH_EN
          state_nxt = FLUSH;
`endif
        end else begin
          // Exit on cnt==1 so the decrement lands on 0 and never wraps
          cnt_nxt = cnt - 1'b1;
          if (cnt == MC_CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        // EX result is captured this cycle; only the ID bubble may remain
        if (stallreq_id) stall_c = STALL_LU;
        cnt_nxt   = '0;
        state_nxt = IDLE;
`ifdef EX_STALL_CTRL_FLUSH_EN
        if (flush_hit) state_nxt = FLUSH;
`endif
      end
`ifdef EX_STALL_CTRL_FLUSH_EN
      FLUSH: begin
        cnt_nxt   = '0;
        state_nxt = flush_hit ? FLUSH : IDLE;
      end
`endif
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State-only outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mc_busy <= 1'b0;
      mc_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mc_busy <= (state_nxt == RUN);
      mc_done <= (state_nxt == DONE);
    end
  end

`ifdef EX_STALL_CTRL_FLUSH_EN
  logic flush_r;
  always_ff @(posedge clk) begin
    if (rst) flush_r <= 1'b0;
    else     flush_r <= (state_nxt == FLUSH);
  end
  assign flush = flush_r;
`else
  assign flush = 1'b0;
`endif

  // No stall may leak out while reset is asserted.
  assign stall  = rst ? 6'b000000 : stall_c;
  assign mc_cnt = cnt;

endmodule

// File: doc/ex_stall_ctrl.md
# ex_stall_ctrl

Pipeline stall/flush controller for the six-stage MIPS core. It sequences multi-cycle EX operations such as multiply-accumulate and divide, and merges load-use stall requests from ID into one per-stage stall vector. That vector drives pc_reg, if_id, id_ex, ex_mem and mem_wb. It also turns exception/redirect requests from MEM into a one-cycle pipeline flush that aborts any EX sequence in progress.

## Interface
Parameters:
- MC_CNT_W, 6, width of the multi-cycle length input and the down-counter.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stallreq_id  in  1  load-use hazard from ID; combinational, level.
- mc_start  in  1  EX holds a multi-cycle op this cycle; sampled only in IDLE.
- mc_len  in  MC_CNT_W  extra EX cycles the op needs (N); valid with mc_start.
- flush_req  in  1  exception/redirect request from MEM; level.
- stall  out  6  per-stage hold: [0] pc, [1] if_id, [2] id_ex input/ID, [3] EX, [4] MEM, [5] WB.
- flush  out  1  pipeline registers load NOP values this cycle.
- mc_busy  out  1  multi-cycle sequence running (state RUN).
- mc_cnt  out  MC_CNT_W  remaining count register; 0 outside RUN.
- mc_done  out  1  one-cycle pulse; EX result is final and captured by ex_mem.

## Operation
- FSM states: IDLE, RUN, DONE, FLUSH; 2-bit state register.
- IDLE:
  - flush_req=1: go to FLUSH.
  - Otherwise, mc_start=1 and N≥1: stall=6'b001111 this cycle and cnt<=N-1. Go to DONE if N==1, else go to RUN.
  - mc_start=1 with N==0 is a single-cycle op: no stall, stay in IDLE, no mc_done.
  - Otherwise stay in IDLE.
- RUN:
  - stall=6'b001111, mc_busy=1, cnt<=cnt-1 each cycle.
  - Go to DONE in the cycle where cnt==1.
  - mc_start is ignored.
- DONE:
  - mc_done=1 and stall[3:0] released; go to IDLE.
  - mc_start is ignored, because the next instruction enters EX only after this cycle.
- FLUSH:
  - flush=1, stall=6'b000000; go to IDLE.
  - If flush_req is still 1, stay in FLUSH, with flush held for one cycle per asserted cycle.
- stallreq_id:
  - IDLE or DONE: stall |= 6'b000111.
  - RUN: already covered by 6'b001111.
  - FLUSH: ignored.
- Priority, highest first: rst, flush_req, multi-cycle sequence, stallreq_id.
- flush_req in RUN or DONE aborts the sequence. cnt<=0, next state FLUSH, and no mc_done pulse.
- Output types:
  - stall is Mealy, a function of state and current inputs.
  - flush, mc_busy and mc_done depend on state only.
  - mc_cnt is the register value.
- cnt is unsigned MC_CNT_W bits. N max = 2^MC_CNT_W-1. Decrement never wraps, because the exit condition is cnt==1.

## Timing
- Reset values: state IDLE, cnt 0, stall 0, flush 0, mc_busy 0, mc_cnt 0, mc_done 0.
- Reset mid-sequence aborts with no mc_done.
- Multi-cycle op of length N≥1, start seen in cycle T:
  - stall asserted in cycles T..T+N-1, exactly N cycles.
  - mc_done in cycle T+N.
  - Earliest new mc_start is sampled in T+N+1.
- flush_req in cycle T: flush=1 in cycle T+1, which is one-cycle latency. Pipeline runs unstalled from T+2 if flush_req has dropped.
- Back-to-back ops: minimum one DONE cycle between sequences.

## Configuration
- Macro EX_STALL_CTRL_FLUSH_EN.
- Defined: FLUSH state and flush_req handling as described.
- Undefined:
  - flush_req is ignored.
  - flush is tied to 0.
  - FLUSH state is unreachable and not synthesized; the FSM uses IDLE/RUN/DONE only.
  - Multi-cycle sequences always run to mc_done unless rst.

## Test plan
- Reset mid-RUN (N=10, rst at cycle 4): next cycle all outputs 0, state IDLE, no mc_done pulse ever.
- mc_start with N=5 at cycle T:
  - stall=001111 in T..T+4.
  - mc_cnt 4,3,2,1 in T+1..T+4.
  - mc_done=1 only in T+5, stall=0 in T+5.
- mc_start with N=1 then N=0:
  - N=1: one stall cycle, mc_done next cycle.
  - N=0: no stall, no mc_done.
- stallreq_id=1 in IDLE gives stall=000111. stallreq_id=1 during RUN gives stall=001111. stallreq_id=1 in DONE gives stall=000111 with mc_done=1.
- With EX_STALL_CTRL_FLUSH_EN: flush_req pulse at RUN cycle 3 of N=8 → flush=1 next cycle, stall=0, mc_done never asserted, IDLE after. flush_req held 3 cycles gives flush=1 for 3 consecutive cycles.
- Without EX_STALL_CTRL_FLUSH_EN: same flush_req stimulus → flush stays 0, sequence completes with mc_done at T+8.
